// File: rtl/boolean_input_debouncer_if.sv
// boolean_input_debouncer_if: raw switch inputs and debounced outputs of the debouncer
interface boolean_input_debouncer_if;
  logic [2:0] sw_in;
  logic [2:0] abc_out;
  logic       change;
  logic       busy;
  modport master (output sw_in, input abc_out, change, busy);
  modport slave (input sw_in, output abc_out, change, busy);
endinterface

// File: rtl/boolean_input_debouncer.sv
// boolean_input_debouncer: synchronises and debounces three slide switches, pulsing change on each accepted level
module boolean_input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input logic                      clk,
  input logic                      rst,
  boolean_input_debouncer_if.slave bus
);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0] s, abc_q, upd, pend;
  logic change_q;
  assign s = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      abc_q    <= 3'b000;
      change_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.sw_in};
      abc_q    <= abc_q ^ upd;
      change_q <= |upd;
    end
  end
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [0:0] st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic mis, done;
    // an accepted update always flips the bit, since it only fires on a mismatch
    always_comb begin
      mis   = s[i] ^ abc_q[i];
      done  = mis && (st_q == PENDING ? cnt_q == LAST : STABLE_CYCLES == 1);
      st_d  = mis && !done ? PENDING : IDLE;
      cnt_d = !mis || done ? '0 : (st_q == IDLE ? CNT_W'(1) : cnt_q + 1'b1);
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q  <= IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end
    assign upd[i]  = done;
    assign pend[i] = st_q != IDLE;
  end
  assign bus.abc_out = abc_q;
  assign bus.change  = change_q;
  assign bus.busy    = |pend;
endmodule

// File: tb/tb_boolean_input_debouncer.sv
// tb_boolean_input_debouncer: directed scenarios checked by literal expectations and a per-cycle run-length model
module tb_boolean_input_debouncer;
  localparam int SYNC = 2;
  localparam int STABLE = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  boolean_input_debouncer_if bus();
  boolean_input_debouncer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;

  // model: a bit flips once its delayed input has disagreed for STABLE consecutive edges
  logic [2:0] m_pipe [SYNC];
  logic [2:0] m_abc, m_s;
  logic m_chg;
  int run [3];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC; k++) m_pipe[k] = 3'b000;
      m_abc = 3'b000;
      m_chg = 1'b0;
      for (int c = 0; c < 3; c++) run[c] = 0;
    end else begin
      m_s = m_pipe[SYNC-1];
      m_chg = 1'b0;
      for (int c = 0; c < 3; c++) begin
        run[c] = (m_s[c] != m_abc[c]) ? run[c] + 1 : 0;
        if (run[c] == STABLE) begin
          m_abc[c] = m_s[c];
          run[c] = 0;
          m_chg = 1'b1;
        end
      end
      for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = bus.sw_in;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_abc", 32'(bus.abc_out), 32'(m_abc));
      chk("model_change", 32'(bus.change), 32'(m_chg));
      chk("model_busy", 32'(bus.busy), 32'((run[0] != 0) || (run[1] != 0) || (run[2] != 0)));
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sw_in = 3'b000;
    tick(2);
    rst = 1'b0;
  endtask

  int pulses;
  initial begin
    bus.sw_in = 3'b111;
    // 1: reset with switches high, then debounce from zero
    tick(1);
    chk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_abc", 32'(bus.abc_out), 32'h0);
      chk("rst_change", 32'(bus.change), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      tick(1);
    end
    rst = 1'b0;
    tick(5);
    chk("rst_abc_edge4", 32'(bus.abc_out), 32'h0);
    tick(1);
    chk("rst_abc_edge5", 32'(bus.abc_out), 32'h7);
    chk("rst_change_edge5", 32'(bus.change), 32'h1);
    // 2: clean edge
    do_reset();
    bus.sw_in = 3'b100;
    tick(2);
    chk("clean_busy_edge1", 32'(bus.busy), 32'h0);
    tick(1);
    chk("clean_busy_edge2", 32'(bus.busy), 32'h1);
    tick(2);
    chk("clean_abc_edge4", 32'(bus.abc_out), 32'h0);
    tick(1);
    chk("clean_abc_edge5", 32'(bus.abc_out), 32'h4);
    chk("clean_change_edge5", 32'(bus.change), 32'h1);
    chk("clean_busy_edge5", 32'(bus.busy), 32'h0);
    tick(1);
    chk("clean_change_edge6", 32'(bus.change), 32'h0);
    // 3: three-cycle glitch is rejected
    do_reset();
    bus.sw_in = 3'b001;
    pulses = 0;
    tick(3);
    pulses += int'(bus.change);
    bus.sw_in = 3'b000;
    for (int k = 0; k < 9; k++) begin
      tick(1);
      pulses += int'(bus.change);
    end
    chk("glitch_pulses", 32'(pulses), 32'h0);
    chk("glitch_abc", 32'(bus.abc_out), 32'h0);
    chk("glitch_busy", 32'(bus.busy), 32'h0);
    // 4: two channels together give one pulse
    do_reset();
    bus.sw_in = 3'b011;
    pulses = 0;
    tick(5);
    pulses += int'(bus.change);
    tick(1);
    chk("simul_abc_edge5", 32'(bus.abc_out), 32'h3);
    pulses += int'(bus.change);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      pulses += int'(bus.change);
    end
    chk("simul_pulses", 32'(pulses), 32'h1);
    // 5: bouncing input, then held high
    do_reset();
    for (int k = 0; k < 10; k++) begin
      bus.sw_in = (k % 2 == 0) ? 3'b010 : 3'b000;
      tick(2);
      chk("bounce_abc", 32'(bus.abc_out), 32'h0);
    end
    bus.sw_in = 3'b010;
    tick(5);
    chk("bounce_abc_edge4", 32'(bus.abc_out), 32'h0);
    tick(1);
    chk("bounce_abc_edge5", 32'(bus.abc_out), 32'h2);
    // 6: reset mid-count discards progress
    do_reset();
    bus.sw_in = 3'b100;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("midrst_abc", 32'(bus.abc_out), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    tick(1);
    rst = 1'b0;
    tick(5);
    chk("midrst_abc_edge4", 32'(bus.abc_out), 32'h0);
    tick(1);
    chk("midrst_abc_edge5", 32'(bus.abc_out), 32'h4);
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
